codec_config_sequencer: RTL and testbench



---
 rtl/codec_config_sequencer.sv | 160 ++++++++++++++++
 tb/tb_codec_config_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_config_sequencer.sv
// rtl/codec_config_sequencer.sv - codec power-up register write sequencer
// Walks the fixed codec init table through an I2C byte engine, retrying NACKs and spacing writes.
`timescale 1ns/1ps
module codec_config_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_REGS   = 11,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 1200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        start_i,
  output logic        i2c_req_o,
  output logic [6:0]  i2c_addr_o,
  output logic [15:0] i2c_data_o,
  input  logic        i2c_done_i,
  input  logic        i2c_ack_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        audio_en_o,
  output logic [3:0]  idx_o
);

  localparam int              GW        = $clog2(GAP_CYCLES + 1);
  localparam int              RW        = $clog2(MAX_RETRY + 1);
  localparam logic [3:0]      LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [RW-1:0]   RETRY_TOP = RW'(MAX_RETRY);
  localparam logic [GW-1:0]   GAP_LOAD  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_idx;
  logic [RW-1:0] r_retry;
  logic [GW-1:0] r_gap_cnt;
  logic          r_acked;

  logic          w_can_retry;
  logic          w_gap_zero;
  logic          w_req;
  logic [15:0]   w_word;

  assign w_can_retry = (r_retry != RETRY_TOP);
  assign w_gap_zero  = (r_gap_cnt == '0);

  function automatic logic [15:0] table_word(input logic [3:0] idx);
    case (idx)
      4'd0:    table_word = 16'h1E00;
      4'd1:    table_word = 16'h0C10;
      4'd2:    table_word = 16'h0017;
      4'd3:    table_word = 16'h0217;
      4'd4:    table_word = 16'h0479;
      4'd5:    table_word = 16'h0679;
      4'd6:    table_word = 16'h0812;
      4'd7:    table_word = 16'h0A00;
      4'd8:    table_word = 16'h0E08;
      4'd9:    table_word = 16'h1000;
      4'd10:   table_word = 16'h1201;
      default: table_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (en_i) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) w_next_state = S_ISSUE;
        end
        S_ISSUE: w_next_state = S_WAIT;
        S_WAIT: begin
          if (i2c_done_i) begin
            if (!i2c_ack_err_i || w_can_retry) w_next_state = S_GAP;
            else                                w_next_state = S_ERROR;
          end
        end
        S_GAP: begin
          if (w_gap_zero) begin
            if (r_acked && (r_idx == LAST_IDX)) w_next_state = S_DONE;
            else                                 w_next_state = S_ISSUE;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Entry index advances on the GAP->ISSUE edge so idx_o names the entry being written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx     <= 4'd0;
      r_retry   <= '0;
      r_gap_cnt <= '0;
      r_acked   <= 1'b0;
    end else if (en_i) begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_idx   <= 4'd0;
            r_retry <= '0;
            r_acked <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i2c_done_i) begin
            if (!i2c_ack_err_i) begin
              r_gap_cnt <= GAP_LOAD;
              r_retry   <= '0;
              r_acked   <= 1'b1;
            end else if (w_can_retry) begin
              r_gap_cnt <= GAP_LOAD;
              r_retry   <= r_retry + RW'(1);
              r_acked   <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (!w_gap_zero) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end else if (r_acked && (r_idx != LAST_IDX)) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_req      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    w_word     = table_word(r_idx);
    i2c_req_o  = w_req;
    i2c_addr_o = DEV_ADDR;
    i2c_data_o = w_req ? w_word : 16'h0000;
    busy_o     = w_req || (r_state == S_GAP);
    done_o     = (r_state == S_DONE);
    audio_en_o = (r_state == S_DONE);
    err_o      = (r_state == S_ERROR);
    idx_o      = r_idx;
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb/tb_codec_config_sequencer.sv - scoreboard bench for codec_config_sequencer
// Model expands a per-entry NACK plan into the expected write stream; a monitor checks each request.
`timescale 1ns/1ps
module tb_codec_config_sequencer;

  localparam int NREG  = 11;
  localparam int MAXR  = 3;
  localparam int GAP   = 1200;

  logic        clk;
  logic        rst_ni;
  logic        en_i;
  logic        start_i;
  logic        i2c_req_o;
  logic [6:0]  i2c_addr_o;
  logic [15:0] i2c_data_o;
  logic        i2c_done_i;
  logic        i2c_ack_err_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        audio_en_o;
  logic [3:0]  idx_o;

  logic        r_done, r_err, s_done, s_err;
  assign i2c_done_i    = r_done | s_done;
  assign i2c_ack_err_i = r_err | s_err;

  codec_config_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .start_i      (start_i),
    .i2c_req_o    (i2c_req_o),
    .i2c_addr_o   (i2c_addr_o),
    .i2c_data_o   (i2c_data_o),
    .i2c_done_i   (i2c_done_i),
    .i2c_ack_err_i(i2c_ack_err_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .audio_en_o   (audio_en_o),
    .idx_o        (idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] tbl [NREG] = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                              16'h0812, 16'h0A00, 16'h0E08, 16'h1000, 16'h1201};

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q [$];
  logic        resp_q [$];
  int          nack_plan [NREG];
  int          exp_err, exp_idx;
  int          stall_idx = -1;
  int          last_rise = -1;
  int          cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: each entry is written (NACKs + 1) times; too many NACKs ends the run at that entry.
  task automatic build_model();
    exp_q.delete();
    resp_q.delete();
    exp_err = 0;
    exp_idx = NREG - 1;
    for (int i = 0; i < NREG; i++) begin
      if (nack_plan[i] > MAXR) begin
        for (int k = 0; k <= MAXR; k++) begin
          exp_q.push_back(tbl[i]);
          resp_q.push_back(1'b1);
        end
        exp_err = 1;
        exp_idx = i;
        break;
      end
      for (int k = 0; k < nack_plan[i]; k++) begin
        exp_q.push_back(tbl[i]);
        resp_q.push_back(1'b1);
      end
      exp_q.push_back(tbl[i]);
      resp_q.push_back(1'b0);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    last_rise = -1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit hit = 0;
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (done_o || err_o) begin
        hit = 1;
        break;
      end
    end
    chk({name, "_finished"}, 32'(hit), 32'd1);
    chk({name, "_done"}, 32'(done_o), 32'(exp_err == 0));
    chk({name, "_audio_en"}, 32'(audio_en_o), 32'(exp_err == 0));
    chk({name, "_err"}, 32'(err_o), 32'(exp_err));
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
    chk({name, "_idx"}, 32'(idx_o), 32'(exp_idx));
    chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Responder: acks after a random latency, outcome taken from the model's response queue.
  always begin
    @(negedge clk);
    if (i2c_req_o && rst_ni) begin
      automatic int lat = $urandom_range(1, 20);
      for (int k = 0; k < lat && i2c_req_o; k++) @(negedge clk);
      while (i2c_req_o && (int'(idx_o) == stall_idx)) @(negedge clk);
      if (i2c_req_o) begin
        r_err  = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
        r_done = 1'b1;
        @(negedge clk);
        r_done = 1'b0;
        r_err  = 1'b0;
      end
    end
  end

  logic        prev_req = 1'b0;
  logic        unstable = 1'b0;
  logic [15:0] cur_word = 16'h0;

  always @(negedge clk) begin
    cyc++;
    if (i2c_req_o && !prev_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 32'(i2c_data_o), 32'hFFFF_FFFF);
      end else begin
        chk("req_data", 32'(i2c_data_o), 32'(exp_q.pop_front()));
      end
      chk("req_addr", 32'(i2c_addr_o), 32'h1A);
      if (last_rise >= 0) chk("req_spacing", 32'((cyc - last_rise) >= GAP + 2), 32'd1);
      last_rise = cyc;
      cur_word  = i2c_data_o;
      unstable  = 1'b0;
    end else if (i2c_req_o && (i2c_data_o != cur_word)) begin
      unstable = 1'b1;
    end
    if (!i2c_req_o && prev_req) chk("data_stable", 32'(unstable), 32'd0);
    prev_req = i2c_req_o;
  end

  initial begin
    logic       idle_bad;
    bit         hit;
    logic [3:0] held_idx;
    rst_ni  = 1'b0;
    en_i    = 1'b1;
    start_i = 1'b0;
    r_done  = 1'b0;
    r_err   = 1'b0;
    s_done  = 1'b0;
    s_err   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(i2c_req_o), 32'd0);
    chk("rst_flags", 32'({busy_o, done_o, err_o, audio_en_o}), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    rst_ni = 1'b1;

    idle_bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ({i2c_req_o, busy_o, done_o, err_o, audio_en_o, idx_o} != '0) idle_bad = 1'b1;
    end
    chk("idle_quiet", 32'(idle_bad), 32'd0);

    en_i = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("en_low_start_busy", 32'(busy_o), 32'd0);
    chk("en_low_start_req", 32'(i2c_req_o), 32'd0);
    en_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_back_still_idle", 32'(busy_o), 32'd0);

    clear_plan();
    build_model();
    pulse_start();
    wait_end("all_ack");

    // Restart from DONE with a simultaneous done pulse: start must win.
    clear_plan();
    nack_plan[3] = 2;
    build_model();
    @(negedge clk);
    last_rise = -1;
    start_i = 1'b1;
    s_done  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    s_done  = 1'b0;
    chk("restart_busy", 32'(busy_o), 32'd1);
    chk("restart_done_clr", 32'({done_o, audio_en_o}), 32'd0);
    wait_end("nack3x2");

    clear_plan();
    nack_plan[5] = 4;
    build_model();
    pulse_start();
    wait_end("nack5x4");

    clear_plan();
    build_model();
    stall_idx = 7;
    pulse_start();
    chk("err_restart_clr", 32'(err_o), 32'd0);
    chk("err_restart_busy", 32'(busy_o), 32'd1);
    hit = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (i2c_req_o && idx_o == 4'd7) begin
        hit = 1;
        break;
      end
    end
    chk("reach_wait_idx7", 32'(hit), 32'd1);
    repeat (5) @(negedge clk);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_req", 32'(i2c_req_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_idx", 32'(idx_o), 32'd0);
    exp_q.delete();
    resp_q.delete();
    stall_idx = -1;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'({busy_o, i2c_req_o, done_o, err_o}), 32'd0);

    for (int i = 0; i < NREG; i++)
      nack_plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXR)) : 0;
    build_model();
    pulse_start();
    hit = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (busy_o && !i2c_req_o && idx_o == 4'd2) begin
        hit = 1;
        break;
      end
    end
    chk("reach_gap_idx2", 32'(hit), 32'd1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    s_done  = 1'b1;
    s_err   = 1'b1;
    @(negedge clk);
    s_done  = 1'b0;
    s_err   = 1'b0;
    chk("gap_start_ignored_idx", 32'(idx_o), 32'd2);
    chk("gap_start_ignored_busy", 32'({busy_o, i2c_req_o}), 32'b10);
    held_idx = idx_o;
    en_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("en_hold_idx", 32'(idx_o), 32'(held_idx));
    chk("en_hold_state", 32'({busy_o, i2c_req_o}), 32'b10);
    en_i = 1'b1;
    wait_end("random_plan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
